// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: three read ports with scoreboard bits,
// one writeback port, one issue port and the ready flag.
interface reg_file_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              ready;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [ADDR_W-1:0] ra3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] rd3;
  logic              busy1;
  logic              busy2;
  logic              busy3;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_a;

  modport master (
    output ra1, ra2, ra3, we, wa, wd, iss_en, iss_a,
    input  ready, rd1, rd2, rd3, busy1, busy2, busy3
  );

  modport slave (
    input  ra1, ra2, ra3, we, wa, wd, iss_en, iss_a,
    output ready, rd1, rd2, rd3, busy1, busy2, busy3
  );
endinterface

// File: rtl/reg_file_sb.sv
// Three-read/one-write register file with write-first bypass, a per-entry
// pending-producer scoreboard, and a reset-time sweep that zeroes every entry.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              ready_q;
  logic [DEPTH-1:0]  busy_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              live;
  logic              wa_zero;
  logic              ia_zero;
  logic              we_ok;
  logic              iss_ok;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // Outputs are only meaningful in RUN and with reset released.
  assign live    = ready_q & ~rst;
  assign wa_zero = (ZERO_REG != 0) && (bus.wa == '0);
  assign ia_zero = (ZERO_REG != 0) && (bus.iss_a == '0);
  assign we_ok   = (state == RUN) & bus.we & ~wa_zero;
  assign iss_ok  = (state == RUN) & bus.iss_en & ~ia_zero;

  // Array write port shared between the clear sweep and writeback.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = cnt;
      end else if (we_ok) begin
        mem_we = 1'b1;
        mem_wa = bus.wa;
        mem_wd = bus.wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Control FSM, sweep counter and scoreboard; issue is applied after the
  // writeback clear so a same-cycle new producer keeps the entry pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          busy_q[cnt] <= 1'b0;
          cnt         <= cnt + ADDR_W'(1);
          if (cnt == LAST) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (we_ok)  busy_q[bus.wa]    <= 1'b0;
          if (iss_ok) busy_q[bus.iss_a] <= 1'b1;
        end
        default: begin
          state   <= CLEAR;
          cnt     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [DATA_W-1:0] read_data(
    input logic              en,
    input logic [ADDR_W-1:0] a,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] ent
  );
    if (!en)                              return '0;
    if ((ZERO_REG != 0) && (a == '0))     return '0;
    if (we && (wa == a))                  return wd;
    return ent;
  endfunction

  // A writeback this cycle resolves the hazard before the edge.
  function automatic logic read_busy(
    input logic              en,
    input logic [ADDR_W-1:0] a,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic              b
  );
    return en & b & ~(we && (wa == a));
  endfunction

  assign bus.ready = ready_q;

  assign bus.rd1 = read_data(live, bus.ra1, bus.we, bus.wa, bus.wd, mem[bus.ra1]);
  assign bus.rd2 = read_data(live, bus.ra2, bus.we, bus.wa, bus.wd, mem[bus.ra2]);
  assign bus.rd3 = read_data(live, bus.ra3, bus.we, bus.wa, bus.wd, mem[bus.ra3]);

  assign bus.busy1 = read_busy(live, bus.ra1, bus.we, bus.wa, busy_q[bus.ra1]);
  assign bus.busy2 = read_busy(live, bus.ra2, bus.we, bus.wa, busy_q[bus.ra2]);
  assign bus.busy3 = read_busy(live, bus.ra3, bus.we, bus.wa, busy_q[bus.ra3]);

endmodule
